// File: rtl/key_event_decoder.sv
// Key event decoder: classifies debounced key presses as short, double or long.
// Define KEY_LONG_PRESS_EN to enable the LONG state and long_pulse.
module key_event_decoder #(
  parameter logic [25:0] LONG_MAX = 26'd50_000_000,
  parameter logic [25:0] DBL_MAX  = 26'd15_000_000
) (
  input  logic       sys_clk,
  input  logic       sys_rst,
  input  logic       key_flag,
  input  logic       key_in,
  output logic       short_pulse,
  output logic       double_pulse,
  output logic       long_pulse,
  output logic       busy,
  output logic [7:0] evt_cnt
);

  localparam logic [25:0] LONG_LAST = LONG_MAX - 26'd1;
  localparam logic [25:0] DBL_LAST  = DBL_MAX - 26'd1;

`ifdef KEY_LONG_PRESS_EN
  typedef enum logic [2:0] {IDLE, PRESS1, WAIT2, PRESS2, LONG} state_t;
`else
  typedef enum logic [2:0] {IDLE, PRESS1, WAIT2, PRESS2} state_t;
`endif

  state_t      state, state_nxt;
  logic [25:0] cnt, cnt_nxt;
  logic        short_nxt, double_nxt, event_nxt;
`ifdef KEY_LONG_PRESS_EN
  logic        long_nxt;
`endif

  always_comb begin
    // NOTE: every signal gets a default before the case, so no path can infer a latch.
    state_nxt  = state;
    cnt_nxt    = cnt;
    short_nxt  = 1'b0;
    double_nxt = 1'b0;
`ifdef KEY_LONG_PRESS_EN
    long_nxt   = 1'b0;
`endif
    case (state)
      IDLE: begin
        cnt_nxt = '0;
        if (key_flag) state_nxt = PRESS1;
      end
      PRESS1: begin
        if (key_in) begin
          state_nxt = WAIT2;
          cnt_nxt   = '0;
        end
`ifdef KEY_LONG_PRESS_EN
        else if (cnt == LONG_LAST) begin
          state_nxt = LONG;
          cnt_nxt   = '0;
          long_nxt  = 1'b1;
        end else begin
          cnt_nxt = cnt + 26'd1;
        end
`else
        // Without long-press support the hold is unbounded; cnt just saturates.
        else if (cnt < LONG_LAST) begin
          cnt_nxt = cnt + 26'd1;
        end
`endif
      end
      WAIT2: begin
        // A second press on the timeout edge still counts as a double press.
        if (key_flag) begin
          state_nxt  = PRESS2;
          cnt_nxt    = '0;
          double_nxt = 1'b1;
        end else if (cnt == DBL_LAST) begin
          state_nxt = IDLE;
          cnt_nxt   = '0;
          short_nxt = 1'b1;
        end else begin
          cnt_nxt = cnt + 26'd1;
        end
      end
      PRESS2: begin
        if (key_in) state_nxt = IDLE;
      end
`ifdef KEY_LONG_PRESS_EN
      LONG: begin
        if (key_in) state_nxt = IDLE;
      end
`endif
      default: begin
        state_nxt = IDLE;
        cnt_nxt   = '0;
      end
    endcase
`ifdef KEY_LONG_PRESS_EN
    event_nxt = short_nxt | double_nxt | long_nxt;
`else
    event_nxt = short_nxt | double_nxt;
`endif
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      state        <= IDLE;
      cnt          <= '0;
      short_pulse  <= 1'b0;
      double_pulse <= 1'b0;
      busy         <= 1'b0;
      evt_cnt      <= 8'h00;
    end else begin
      state        <= state_nxt;
      cnt          <= cnt_nxt;
      short_pulse  <= short_nxt;
      double_pulse <= double_nxt;
      busy         <= (state_nxt != IDLE);
      if (event_nxt) evt_cnt <= evt_cnt + 8'd1;
    end
  end

`ifdef KEY_LONG_PRESS_EN
  always_ff @(posedge sys_clk) begin
    if (sys_rst) long_pulse <= 1'b0;
    else         long_pulse <= long_nxt;
  end
`else
  assign long_pulse = 1'b0;
`endif

endmodule

// File: tb/tb_key_event_decoder.sv
// Directed testbench for key_event_decoder with LONG_MAX=20, DBL_MAX=10.
// Exercises the long-press path when KEY_LONG_PRESS_EN is defined, else the no-long path.
module tb_key_event_decoder;

  localparam logic [25:0] LONG_MAX = 26'd20;
  localparam logic [25:0] DBL_MAX  = 26'd10;

  logic       sys_clk = 1'b0;
  logic       sys_rst, key_flag, key_in;
  logic       short_pulse, double_pulse, long_pulse, busy;
  logic [7:0] evt_cnt;

  int n_checks = 0;
  int n_pass   = 0;
  int short_seen, double_seen, long_seen, multi_seen;

  key_event_decoder #(.LONG_MAX(LONG_MAX), .DBL_MAX(DBL_MAX)) dut (
    .sys_clk     (sys_clk),
    .sys_rst     (sys_rst),
    .key_flag    (key_flag),
    .key_in      (key_in),
    .short_pulse (short_pulse),
    .double_pulse(double_pulse),
    .long_pulse  (long_pulse),
    .busy        (busy),
    .evt_cnt     (evt_cnt)
  );

  always #5 sys_clk = ~sys_clk;

  // One rising edge, then sample 1 time unit later and tally any pulses.
  task automatic step();
    @(posedge sys_clk);
    #1;
    if (short_pulse === 1'b1)  short_seen++;
    if (double_pulse === 1'b1) double_seen++;
    if (long_pulse === 1'b1)   long_seen++;
    if (int'(short_pulse) + int'(double_pulse) + int'(long_pulse) > 1) multi_seen++;
  endtask

  task automatic run(input int n);
    repeat (n) step();
  endtask

  task automatic clear_seen();
    short_seen  = 0;
    double_seen = 0;
    long_seen   = 0;
  endtask

  task automatic do_reset();
    sys_rst  = 1'b1;
    key_flag = 1'b0;
    key_in   = 1'b1;
    step();
    sys_rst = 1'b0;
    clear_seen();
  endtask

  // Flag at edge t, release sampled at edge t+hold.
  task automatic press_release(input int hold);
    key_in   = 1'b0;
    key_flag = 1'b1;
    step();
    key_flag = 1'b0;
    run(hold - 1);
    key_in = 1'b1;
    step();
  endtask

  task automatic test_reset();
    do_reset();
    n_checks++;
    if ({short_pulse, double_pulse, long_pulse} !== 3'b000)
      $display("FAIL reset_pulses: got %b want 000", {short_pulse, double_pulse, long_pulse});
    else n_pass++;
    n_checks++;
    if (busy !== 1'b0) $display("FAIL reset_busy: got %b want 0", busy);
    else n_pass++;
    n_checks++;
    if (evt_cnt !== 8'h00) $display("FAIL reset_evt_cnt: got %h want 00", evt_cnt);
    else n_pass++;
  endtask

  task automatic test_single();
    do_reset();
    key_in   = 1'b0;
    key_flag = 1'b1;
    step();
    key_flag = 1'b0;
    n_checks++;
    if (busy !== 1'b1) $display("FAIL single_busy_rise: got %b want 1", busy);
    else n_pass++;
    run(4);
    key_in = 1'b1;
    step();
    clear_seen();
    run(9);
    n_checks++;
    if (short_seen !== 0) $display("FAIL single_early_short: got %0d want 0", short_seen);
    else n_pass++;
    step();
    n_checks++;
    if (short_pulse !== 1'b1) $display("FAIL single_short_t15: got %b want 1", short_pulse);
    else n_pass++;
    n_checks++;
    if (evt_cnt !== 8'h01) $display("FAIL single_evt_cnt: got %h want 01", evt_cnt);
    else n_pass++;
    n_checks++;
    if (busy !== 1'b0) $display("FAIL single_busy_fall: got %b want 0", busy);
    else n_pass++;
    step();
    n_checks++;
    if (short_pulse !== 1'b0) $display("FAIL single_short_width: got %b want 0", short_pulse);
    else n_pass++;
  endtask

  task automatic test_double();
    do_reset();
    press_release(3);
    run(3);
    key_in   = 1'b0;
    key_flag = 1'b1;
    clear_seen();
    step();
    key_flag = 1'b0;
    n_checks++;
    if (double_pulse !== 1'b1 || short_pulse !== 1'b0)
      $display("FAIL double_pulse: got double=%b short=%b want 1 0", double_pulse, short_pulse);
    else n_pass++;
    n_checks++;
    if (evt_cnt !== 8'h01) $display("FAIL double_evt_cnt: got %h want 01", evt_cnt);
    else n_pass++;
    step();
    n_checks++;
    if (double_pulse !== 1'b0 || busy !== 1'b1)
      $display("FAIL double_width: got double=%b busy=%b want 0 1", double_pulse, busy);
    else n_pass++;
    run(2);
    key_in = 1'b1;
    step();
    n_checks++;
    if (busy !== 1'b0) $display("FAIL double_release_busy: got %b want 0", busy);
    else n_pass++;
    clear_seen();
    run(20);
    n_checks++;
    if (short_seen + double_seen + long_seen !== 0 || evt_cnt !== 8'h01)
      $display("FAIL double_quiet: got pulses=%0d evt=%h want 0 01",
               short_seen + double_seen + long_seen, evt_cnt);
    else n_pass++;
  endtask

  task automatic test_collision();
    do_reset();
    press_release(2);
    run(9);
    key_in   = 1'b0;
    key_flag = 1'b1;
    step();
    key_flag = 1'b0;
    n_checks++;
    if (double_pulse !== 1'b1 || short_pulse !== 1'b0)
      $display("FAIL collision_edge: got double=%b short=%b want 1 0", double_pulse, short_pulse);
    else n_pass++;
    clear_seen();
    step();
    key_in = 1'b1;
    step();
    run(15);
    n_checks++;
    if (short_seen !== 0 || evt_cnt !== 8'h01)
      $display("FAIL collision_no_short: got short=%0d evt=%h want 0 01", short_seen, evt_cnt);
    else n_pass++;
  endtask

  task automatic test_reset_mid();
    do_reset();
    press_release(2);
    run(5);
    sys_rst = 1'b1;
    step();
    sys_rst = 1'b0;
    n_checks++;
    if ({short_pulse, double_pulse, long_pulse, busy} !== 4'b0000 || evt_cnt !== 8'h00)
      $display("FAIL midreset_outputs: got %b evt=%h want 0000 00",
               {short_pulse, double_pulse, long_pulse, busy}, evt_cnt);
    else n_pass++;
    clear_seen();
    run(20);
    n_checks++;
    if (short_seen + double_seen + long_seen !== 0 || busy !== 1'b0 || evt_cnt !== 8'h00)
      $display("FAIL midreset_quiet: got pulses=%0d busy=%b evt=%h want 0 0 00",
               short_seen + double_seen + long_seen, busy, evt_cnt);
    else n_pass++;
  endtask

  task automatic test_long();
    do_reset();
    key_in   = 1'b0;
    key_flag = 1'b1;
    step();
    key_flag = 1'b0;
`ifdef KEY_LONG_PRESS_EN
    run(19);
    n_checks++;
    if (long_seen !== 0) $display("FAIL long_early: got %0d want 0", long_seen);
    else n_pass++;
    step();
    n_checks++;
    if (long_pulse !== 1'b1 || evt_cnt !== 8'h01)
      $display("FAIL long_t20: got long=%b evt=%h want 1 01", long_pulse, evt_cnt);
    else n_pass++;
    step();
    n_checks++;
    if (long_pulse !== 1'b0 || busy !== 1'b1)
      $display("FAIL long_width: got long=%b busy=%b want 0 1", long_pulse, busy);
    else n_pass++;
    run(8);
    key_in = 1'b1;
    step();
    clear_seen();
    run(20);
    n_checks++;
    if (short_seen + double_seen + long_seen !== 0 || busy !== 1'b0 || evt_cnt !== 8'h01)
      $display("FAIL long_release: got pulses=%0d busy=%b evt=%h want 0 0 01",
               short_seen + double_seen + long_seen, busy, evt_cnt);
    else n_pass++;
`else
    run(29);
    n_checks++;
    if (long_seen + short_seen !== 0 || busy !== 1'b1)
      $display("FAIL nolong_hold: got pulses=%0d busy=%b want 0 1", long_seen + short_seen, busy);
    else n_pass++;
    key_in = 1'b1;
    step();
    clear_seen();
    run(9);
    n_checks++;
    if (short_seen !== 0) $display("FAIL nolong_early_short: got %0d want 0", short_seen);
    else n_pass++;
    step();
    n_checks++;
    if (short_pulse !== 1'b1 || long_pulse !== 1'b0 || evt_cnt !== 8'h01)
      $display("FAIL nolong_short: got short=%b long=%b evt=%h want 1 0 01",
               short_pulse, long_pulse, evt_cnt);
    else n_pass++;
`endif
  endtask

  task automatic test_wrap();
    do_reset();
    for (int i = 0; i < 256; i++) begin
      press_release(2);
      run(10);
      if (i == 254) begin
        n_checks++;
        if (evt_cnt !== 8'hFF) $display("FAIL wrap_ff: got %h want ff", evt_cnt);
        else n_pass++;
      end
    end
    n_checks++;
    if (evt_cnt !== 8'h00 || short_seen !== 256)
      $display("FAIL wrap_zero: got evt=%h shorts=%0d want 00 256", evt_cnt, short_seen);
    else n_pass++;
  endtask

  initial begin
    sys_rst    = 1'b1;
    key_flag   = 1'b0;
    key_in     = 1'b1;
    multi_seen = 0;
    clear_seen();
    test_reset();
    test_single();
    test_double();
    test_collision();
    test_reset_mid();
    test_long();
    test_wrap();
    n_checks++;
    if (multi_seen !== 0) $display("FAIL one_hot_pulses: got %0d overlapping cycles want 0", multi_seen);
    else n_pass++;
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
